// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared sizes, pixel type and index constants for the 3x3 line buffer
package harris_pkg;
    localparam int WIDTH = 16;
    localparam int IMG_W = 64;
    localparam int IMG_H = 64;

    typedef logic [WIDTH-1:0] pix_t;

    // Controller loop-index slots on in_d
    localparam int D_ROOT = 0;
    localparam int D_Y    = 1;
    localparam int D_X    = 2;

    // Slots on out_d
    localparam int OUT_Y  = 0;
    localparam int OUT_X  = 1;

    // Window index r*3+c; column 2 is where each new column word lands
    localparam int WIN_R0C2 = 2;
    localparam int WIN_R1C2 = 5;
    localparam int WIN_R2C2 = 8;
endpackage

// File: rtl/harris_linebuf_row.sv
// rtl/harris_linebuf_row.sv - one image-row memory, synchronous write, combinational read
module harris_linebuf_row #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    // No reset: stale contents are never exposed because windows are gated on y>=2, x>=2
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/harris_linebuffer_3x3.sv
// rtl/harris_linebuffer_3x3.sv - two-line buffer producing a sliding 3x3 pixel window
module harris_linebuffer_3x3 #(
    parameter int WIDTH = harris_pkg::WIDTH,
    parameter int IMG_W = harris_pkg::IMG_W,
    parameter int IMG_H = harris_pkg::IMG_H
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [2:0][15:0]       in_d,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    output logic [8:0][WIDTH-1:0]  out_win,
    output logic [1:0][15:0]       out_d,
    output logic                   err
);
    import harris_pkg::*;

    localparam int AW = $clog2(IMG_W);

    logic                  w_in_range;
    logic                  w_accept;
    logic [AW-1:0]         w_addr;
    logic [WIDTH-1:0]      w_line0_q;
    logic [WIDTH-1:0]      w_line1_q;

    logic                  r_valid;
    logic [8:0][WIDTH-1:0] r_win;
    logic [1:0][15:0]      r_d;
    logic                  r_err;

    assign w_in_range = (in_d[D_X] < 16'(IMG_W)) && (in_d[D_Y] < 16'(IMG_H));
    assign w_accept   = in_valid && !flush && (in_d[D_ROOT] == 16'd0) && w_in_range;
    assign w_addr     = in_d[D_X][AW-1:0];

    // line0 holds row y-1, line1 holds row y-2; both update on the same accepted beat
    harris_linebuf_row #(.WIDTH(WIDTH), .DEPTH(IMG_W), .AW(AW)) u_row0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (in_data),
        .o_rdata (w_line0_q)
    );

    harris_linebuf_row #(.WIDTH(WIDTH), .DEPTH(IMG_W), .AW(AW)) u_row1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (w_line0_q),
        .o_rdata (w_line1_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_win   <= '0;
            r_d     <= '0;
            r_err   <= 1'b0;
        end else begin
            if (in_valid && !w_in_range) r_err <= 1'b1;
            if (flush) begin
                r_valid <= 1'b0;
                r_win   <= '0;
            end else begin
                r_valid <= w_accept && (in_d[D_Y] >= 16'd2) && (in_d[D_X] >= 16'd2);
                if (w_accept) begin
                    for (int r = 0; r < 3; r++) begin
                        r_win[r*3]   <= r_win[r*3+1];
                        r_win[r*3+1] <= r_win[r*3+2];
                    end
                    r_win[WIN_R0C2] <= w_line1_q;
                    r_win[WIN_R1C2] <= w_line0_q;
                    r_win[WIN_R2C2] <= in_data;
                    r_d[OUT_Y]      <= in_d[D_Y] - 16'd2;
                    r_d[OUT_X]      <= in_d[D_X] - 16'd2;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_win   = r_win;
    assign out_d     = r_d;
    assign err       = r_err;
endmodule

// File: tb/tb_harris_linebuffer_3x3.sv
// tb/tb_harris_linebuffer_3x3.sv - directed ramp-frame bench for harris_linebuffer_3x3
module tb_harris_linebuffer_3x3;
    import harris_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [2:0][15:0] in_d;
    pix_t             in_data;
    logic             out_valid;
    logic [8:0][15:0] out_win;
    logic [1:0][15:0] out_d;
    logic             err;

    int n_chk  = 0;
    int n_pass = 0;
    int win_cnt;
    bit have_win;
    logic [8:0][15:0] last_w;
    logic [1:0][15:0] last_d;

    localparam logic [143:0] FIRST_W = {16'd130, 16'd129, 16'd128, 16'd66, 16'd65, 16'd64,
                                        16'd2, 16'd1, 16'd0};

    harris_linebuffer_3x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_d      (in_d),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_win   (out_win),
        .out_d     (out_d),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // One clock: present a beat, then compare against the ramp-image model (pixel = 64y+x)
    task automatic drive(input bit v, input int root, input int y, input int x,
                         input logic [15:0] data, input bit fl);
        bit acc, exp_v;
        logic [8:0][15:0] exp_w;
        in_valid = v;
        flush    = fl;
        in_d[0]  = 16'(root);
        in_d[1]  = 16'(y);
        in_d[2]  = 16'(x);
        in_data  = data;
        acc   = v && !fl && root == 0 && y < 64 && x < 64;
        exp_v = acc && y >= 2 && x >= 2;
        @(posedge clk);
        #1;
        chk("valid", out_valid, exp_v);
        if (exp_v) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_w[r*3+c] = 16'((y - 2 + r) * 64 + x - 2 + c);
            chk("win", out_win, exp_w);
            chk("out_d", out_d, {16'(x - 2), 16'(y - 2)});
            if (y == 2 && x == 2) chk("first_win", out_win, FIRST_W);
            last_w   = exp_w;
            last_d   = out_d;
            have_win = 1'b1;
            win_cnt++;
        end else if (fl) begin
            chk("flush_win", out_win, '0);
            have_win = 1'b0;
        end else if (acc) begin
            have_win = 1'b0;
        end else if (have_win) begin
            chk("hold", out_win, last_w);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Ramp frame from (sy,sx) up to but excluding (ey,ex); optionally flush at the stop point
    task automatic run_frame(input bit gaps, input int sy, input int sx,
                             input int ey, input int ex, input bit flush_at_stop);
        for (int y = sy; y < 64; y++) begin
            for (int x = (y == sy) ? sx : 0; x < 64; x++) begin
                if (y == ey && x == ex) begin
                    if (flush_at_stop) drive(1'b1, 0, y, x, 16'(y * 64 + x), 1'b1);
                    return;
                end
                while (gaps && ($urandom % 2) == 1) drive(1'b0, 0, y, x, 16'hBEEF, 1'b0);
                drive(1'b1, 0, y, x, 16'(y * 64 + x), 1'b0);
            end
        end
    endtask

    task automatic check_full_frame(input string tag);
        chk({tag, "_count"}, 144'(win_cnt), 144'd3844);
        chk({tag, "_last_d"}, last_d, {16'd61, 16'd61});
        chk({tag, "_last_px"}, last_w[8], 16'd4095);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_d     = '0;
        in_data  = '0;
        have_win = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_win", out_win, '0);
        chk("rst_d", out_d, '0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        win_cnt = 0;
        run_frame(1'b0, 0, 0, 64, 0, 1'b0);
        check_full_frame("cont");
        chk("cont_err", err, 1'b0);

        win_cnt = 0;
        run_frame(1'b1, 0, 0, 64, 0, 1'b0);
        check_full_frame("gaps");

        // Out-of-range and non-root beats in the middle of row 3 must not disturb anything
        run_frame(1'b0, 0, 0, 3, 10, 1'b0);
        drive(1'b1, 0, 3, 64, 16'hDEAD, 1'b0);
        chk("err_set", err, 1'b1);
        drive(1'b1, 0, 64, 10, 16'hDEAD, 1'b0);
        drive(1'b1, 1, 3, 10, 16'hDEAD, 1'b0);
        run_frame(1'b0, 3, 10, 5, 0, 1'b0);
        chk("err_sticky", err, 1'b1);

        run_frame(1'b0, 0, 0, 10, 30, 1'b1);
        chk("flush_keeps_err", err, 1'b1);
        win_cnt = 0;
        run_frame(1'b0, 0, 0, 64, 0, 1'b0);
        check_full_frame("post_flush");

        run_frame(1'b0, 0, 0, 20, 5, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_win", out_win, '0);
        chk("async_rst_d", out_d, '0);
        chk("async_rst_err", err, 1'b0);
        have_win = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        win_cnt = 0;
        run_frame(1'b0, 0, 0, 64, 0, 1'b0);
        check_full_frame("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
